// File: rtl/servant_timer_pkg.sv
// servant_timer_pkg: register map and bit positions shared by the multi-channel timer.
package servant_timer_pkg;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_CMP    = 2'd1,
        REG_COUNT  = 2'd2,
        REG_STATUS = 2'd3
    } reg_off_e;

    localparam int unsigned CTRL_ENABLE    = 0;
    localparam int unsigned CTRL_PERIODIC  = 1;
    localparam int unsigned CTRL_IRQ_EN    = 2;
    localparam int unsigned CTRL_BITS      = 3;
    localparam int unsigned STATUS_PENDING = 0;

endpackage

// File: rtl/servant_timer_channel.sv
// servant_timer_channel: one timer channel holding count, compare, control and the sticky
// pending flag; advances only on tick while enabled.
module servant_timer_channel
    import servant_timer_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 tick_i,
    input  logic                 we_ctrl_i,
    input  logic                 we_cmp_i,
    input  logic                 we_count_i,
    input  logic                 we_status_i,
    input  logic [31:0]          wdat_i,
    output logic [CTRL_BITS-1:0] ctrl_o,
    output logic [WIDTH-1:0]     cmp_o,
    output logic [WIDTH-1:0]     count_o,
    output logic                 pending_o,
    output logic                 irq_o
);

    logic [CTRL_BITS-1:0] ctrl_q, ctrl_d;
    logic [WIDTH-1:0]     cmp_q, cmp_d;
    logic [WIDTH-1:0]     count_q, count_d;
    logic                 pending_q, pending_d;
    logic                 active;
    logic                 match;

    // Bus writes are applied last so they override the tick-driven update on the same edge,
    // except pending where a match outranks the write-1-to-clear.
    always_comb begin
        active  = tick_i & ctrl_q[CTRL_ENABLE];
        match   = active & (count_q == cmp_q);

        count_d = count_q;
        if (active && !match) begin
            count_d = count_q + WIDTH'(1);
        end else if (match && ctrl_q[CTRL_PERIODIC]) begin
            count_d = '0;
        end
        if (we_count_i) begin
            count_d = wdat_i[WIDTH-1:0];
        end

        ctrl_d = ctrl_q;
        if (match && !ctrl_q[CTRL_PERIODIC]) begin
            ctrl_d[CTRL_ENABLE] = 1'b0;
        end
        if (we_ctrl_i) begin
            ctrl_d = wdat_i[CTRL_BITS-1:0];
        end

        cmp_d = we_cmp_i ? wdat_i[WIDTH-1:0] : cmp_q;

        pending_d = pending_q;
        if (we_status_i && wdat_i[STATUS_PENDING]) begin
            pending_d = 1'b0;
        end
        if (match) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q    <= '0;
            cmp_q     <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            cmp_q     <= cmp_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    assign ctrl_o    = ctrl_q;
    assign cmp_o     = cmp_q;
    assign count_o   = count_q;
    assign pending_o = pending_q;
    assign irq_o     = pending_q & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: rtl/servant_multi_timer.sv
// servant_multi_timer: Wishbone slave with CHANNELS independent timer/comparator channels.
// Define SERVANT_TIMER_PRESCALE_EN to tick once every PRESCALE clocks instead of every clock.
module servant_multi_timer
    import servant_timer_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned PRESCALE = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [$clog2(CHANNELS)+1:0]   i_wb_adr,
    input  logic [31:0]                   i_wb_dat,
    input  logic                          i_wb_we,
    input  logic                          i_wb_cyc,
    output logic [31:0]                   o_wb_rdt,
    output logic                          o_wb_ack,
    output logic                          o_irq
);

    localparam int unsigned AW = $clog2(CHANNELS) + 2;
    localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CW-1:0]        chan;
    reg_off_e             reg_sel;
    logic                 strobe;
    logic                 tick;
    logic                 ack_q, ack_d;
    logic [31:0]          rdt_q, rdt_d;
    logic [31:0]          rd_mux;

    logic [CTRL_BITS-1:0] ctrl_w    [CHANNELS];
    logic [WIDTH-1:0]     cmp_w     [CHANNELS];
    logic [WIDTH-1:0]     count_w   [CHANNELS];
    logic [CHANNELS-1:0]  pending_w;
    logic [CHANNELS-1:0]  irq_w;

    if (CHANNELS > 1) begin : g_chan_sel
        assign chan = i_wb_adr[AW-1:2];
    end else begin : g_chan_one
        assign chan = '0;
    end

    assign reg_sel = reg_off_e'(i_wb_adr[1:0]);
    assign strobe  = i_wb_cyc & ~ack_q;

`ifdef SERVANT_TIMER_PRESCALE_EN
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] presc_q, presc_d;

    always_comb begin
        tick    = (presc_q == PW'(PRESCALE - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic wr_sel;
        assign wr_sel = strobe & i_wb_we & (chan == CW'(c));

        servant_timer_channel #(
            .WIDTH(WIDTH)
        ) u_channel (
            .clk_i       (i_clk),
            .rst_ni      (i_rst_n),
            .tick_i      (tick),
            .we_ctrl_i   (wr_sel && (reg_sel == REG_CTRL)),
            .we_cmp_i    (wr_sel && (reg_sel == REG_CMP)),
            .we_count_i  (wr_sel && (reg_sel == REG_COUNT)),
            .we_status_i (wr_sel && (reg_sel == REG_STATUS)),
            .wdat_i      (i_wb_dat),
            .ctrl_o      (ctrl_w[c]),
            .cmp_o       (cmp_w[c]),
            .count_o     (count_w[c]),
            .pending_o   (pending_w[c]),
            .irq_o       (irq_w[c])
        );
    end

    // Read data is sampled from the registers before any same-edge write lands.
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_CTRL:   rd_mux[CTRL_BITS-1:0] = ctrl_w[chan];
            REG_CMP:    rd_mux[WIDTH-1:0]     = cmp_w[chan];
            REG_COUNT:  rd_mux[WIDTH-1:0]     = count_w[chan];
            REG_STATUS: rd_mux[STATUS_PENDING] = pending_w[chan];
            default:    rd_mux = '0;
        endcase
        ack_d = strobe;
        rdt_d = strobe ? rd_mux : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack_q <= 1'b0;
            rdt_q <= '0;
        end else begin
            ack_q <= ack_d;
            rdt_q <= rdt_d;
        end
    end

    assign o_wb_ack = ack_q;
    assign o_wb_rdt = rdt_q;
    assign o_irq    = |irq_w;

endmodule

// File: tb/tb_servant_multi_timer.sv
// tb_servant_multi_timer: directed and randomized bus traffic against a behavioural timer model;
// read data, ack timing and the IRQ line are checked through a scoreboard queue.
`timescale 1ns/1ps
module tb_servant_multi_timer;

    localparam int unsigned     WIDTH    = 32;
    localparam int unsigned     CHANNELS = 4;
    localparam int unsigned     PRESCALE = 16;
    localparam longint unsigned MASK     = (64'd1 << WIDTH) - 64'd1;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  adr   = '0;
    logic [31:0] dat   = '0;
    logic        we    = 1'b0;
    logic        cyc   = 1'b0;
    logic [31:0] rdt;
    logic        ack;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    longint unsigned m_cnt [CHANNELS];
    longint unsigned m_cmp [CHANNELS];
    bit              m_en  [CHANNELS];
    bit              m_per [CHANNELS];
    bit              m_ien [CHANNELS];
    bit              m_pend[CHANNELS];
    bit              m_ack;
    bit              m_irq;
    int unsigned     m_presc;
    logic [31:0]     exp_q[$];

    servant_multi_timer #(
        .WIDTH   (WIDTH),
        .CHANNELS(CHANNELS),
        .PRESCALE(PRESCALE)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_wb_adr(adr),
        .i_wb_dat(dat),
        .i_wb_we (we),
        .i_wb_cyc(cyc),
        .o_wb_rdt(rdt),
        .o_wb_ack(ack),
        .o_irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input int unsigned c, input int unsigned r);
        case (r)
            0:       return {29'd0, m_ien[c], m_per[c], m_en[c]};
            1:       return 32'(m_cmp[c]);
            2:       return 32'(m_cnt[c]);
            default: return {31'd0, m_pend[c]};
        endcase
    endfunction

    function automatic bit next_edge_ticks();
`ifdef SERVANT_TIMER_PRESCALE_EN
        return m_presc == PRESCALE - 1;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            m_cnt[c] = 0; m_cmp[c] = 0; m_en[c] = 0;
            m_per[c] = 0; m_ien[c] = 0; m_pend[c] = 0;
        end
        m_ack   = 0;
        m_irq   = 0;
        m_presc = 0;
        exp_q.delete();
    endtask

    // One clock edge of the timer as the register map describes it.
    task automatic model_step();
        bit              strobe, wr, tick, match, mine, n_en, n_pend;
        int unsigned     sc, sr;
        bit [31:0]       d;
        longint unsigned n_cnt;
        strobe = cyc && !m_ack;
        sc     = adr[3:2];
        sr     = adr[1:0];
        d      = dat;
        wr     = strobe && we;
        if (strobe) exp_q.push_back(model_read(sc, sr));
        tick = next_edge_ticks();
`ifdef SERVANT_TIMER_PRESCALE_EN
        m_presc = (m_presc + 1) % PRESCALE;
`endif
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            mine  = wr && (sc == c);
            match = tick && m_en[c] && (m_cnt[c] == m_cmp[c]);
            n_cnt = m_cnt[c];
            if (tick && m_en[c])
                n_cnt = match ? (m_per[c] ? 0 : m_cnt[c]) : ((m_cnt[c] + 1) & MASK);
            if (mine && sr == 2) n_cnt = d & MASK;
            n_en = m_en[c];
            if (match && !m_per[c]) n_en = 0;
            n_pend = m_pend[c];
            if (mine && sr == 3 && d[0]) n_pend = 0;
            if (match) n_pend = 1;
            if (mine && sr == 0) begin
                n_en     = d[0];
                m_per[c] = d[1];
                m_ien[c] = d[2];
            end
            if (mine && sr == 1) m_cmp[c] = d & MASK;
            m_cnt[c]  = n_cnt;
            m_en[c]   = n_en;
            m_pend[c] = n_pend;
        end
        m_ack = strobe;
        m_irq = 0;
        for (int unsigned c = 0; c < CHANNELS; c++) m_irq |= m_pend[c] & m_ien[c];
    endtask

    task automatic model_loop();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            check("ack", {31'd0, ack}, {31'd0, m_ack});
            if (ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rdt_unexpected actual=0x%08h required=no_ack at %0t", rdt, $time);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (rdt !== e) begin
                        failures++;
                        $display("FAIL rdt actual=0x%08h required=0x%08h at %0t", rdt, e, $time);
                    end
                end
            end else begin
                check("rdt_idle", rdt, 32'd0);
            end
            check("irq", {31'd0, irq}, {31'd0, m_irq});
        end
    endtask

    task automatic bus_now(input bit w, input logic [3:0] a, input logic [31:0] d);
        bit got;
        got = 0;
        cyc = 1'b1; we = w; adr = a; dat = d;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1;
                break;
            end
        end
        cyc = 1'b0; we = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL bus_ack_timeout actual=no_ack required=ack adr=%0h at %0t", a, $time);
        end
    endtask

    task automatic bus(input bit w, input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_now(w, a, d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge just before the edge on which channel c will match.
    task automatic wait_match(input int unsigned c);
        bit hit;
        hit = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (m_en[c] && m_cnt[c] == m_cmp[c] && next_edge_ticks()) begin
                hit = 1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL wait_match_timeout actual=no_match required=match ch=%0d at %0t", c, $time);
        end
    endtask

    task automatic read_all();
        for (int unsigned c = 0; c < CHANNELS; c++)
            for (int unsigned r = 0; r < 4; r++)
                bus(1'b0, 4'((c << 2) | r), 32'd0);
    endtask

    initial begin
        model_reset();
        fork
            model_loop();
            monitor_loop();
        join_none

        idle(3);
        rst_n = 1'b1;

        read_all();

        // ch1 periodic, CMP=4
        bus(1, 4'h5, 32'd4);
        bus(1, 4'h4, 32'd7);
        for (int i = 0; i < 6; i++) bus(0, 4'h6, 0);
        idle(7);
        bus(0, 4'h7, 0);
        bus(1, 4'h7, 32'd1);
        idle(2);

        // ch2 one-shot, CMP=3
        bus(1, 4'h9, 32'd3);
        bus(1, 4'h8, 32'd5);
        idle(10);
        bus(0, 4'h8, 0);
        bus(0, 4'hA, 0);
        idle(8);
        bus(1, 4'hB, 32'd1);

        // ch3 wrap through all-ones
        bus(1, 4'hE, 32'hFFFF_FFFA);
        bus(1, 4'hD, 32'd2);
        bus(1, 4'hC, 32'd7);
        for (int i = 0; i < 10; i++) bus(0, 4'hE, 0);
        bus(0, 4'hF, 0);

        // same-edge races on ch1 (still periodic, CMP=4)
        wait_match(1);
        bus_now(1, 4'h7, 32'd1);
        bus(0, 4'h7, 0);
        wait_match(1);
        bus_now(1, 4'h6, 32'd2);
        bus(0, 4'h6, 0);
        bus(1, 4'h7, 32'd1);

        // ch2 one-shot auto-disable vs CTRL write on the match edge
        bus(1, 4'hA, 32'd0);
        bus(1, 4'h8, 32'd5);
        wait_match(2);
        bus_now(1, 4'h8, 32'd3);
        bus(0, 4'h8, 0);

        // ch0 CMP=1 periodic (every 2 ticks; 32 clocks when prescaled)
        bus(1, 4'h1, 32'd1);
        bus(1, 4'h0, 32'd7);
        idle(70);
        bus(0, 4'h3, 0);
        bus(1, 4'h3, 32'd1);

        for (int n = 0; n < 300; n++) begin
            logic [3:0]  a;
            logic [31:0] d;
            bit          w;
            a = 4'($urandom_range(0, 15));
            w = 1'($urandom_range(0, 1));
            case (a[1:0])
                2'd0: d = ($urandom & 32'hFFFF_FFF8) | 32'($urandom_range(0, 7));
                2'd1: d = 32'($urandom_range(0, 6));
                2'd2: d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 5))
                                                      : 32'($urandom_range(0, 6));
                default: d = $urandom;
            endcase
            bus(w, a, d);
            idle($urandom_range(0, 6));
        end

        // async reset with a bus cycle in flight and IRQs live
        bus(1, 4'h5, 32'd2);
        bus(1, 4'h4, 32'd7);
        idle(6);
        @(negedge clk);
        cyc = 1'b1; we = 1'b0; adr = 4'h6;
        #2 rst_n = 1'b0;
        #1;
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_rdt", rdt, 32'd0);
        @(negedge clk);
        cyc = 1'b0;
        idle(1);
        rst_n = 1'b1;
        read_all();
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
